mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit in the E stage; executes MULT, MULTU, DIV and DIVU.
- Drives the hazard unit's isMulOrDivComputingE input through busy_o. Holds F through W while it is computing.
- Hands the HI/LO result to the E/M pipeline register on the cycle the instruction is released.
- Abortable by an E-stage exception so that the flush never collides with its stall.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, width of the divide iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start_i  input  1  E-stage instruction is a mul/div; held high while E is stalled.
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- a_i  input  WIDTH  rs operand after E-stage forwarding.
- b_i  input  WIDTH  rt operand after E-stage forwarding.
- annul_i  input  1  E-stage exception (haveExceptionE); aborts the operation.
- stall_i  input  1  external stall of E other than this unit; holds DONE.
- busy_o  output  1  to isMulOrDivComputingE.
- valid_o  output  1  hi_o/lo_o hold the result of the E-stage instruction.
- hi_o  output  WIDTH  HI result (product high word or remainder).
- lo_o  output  WIDTH  LO result (product low word or quotient).

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; counter, hi_o, lo_o and valid_o become 0.
  - busy_o is forced to 0 while rst=0.
  - Reset mid-operation discards all partial state.
- busy_o (combinational) = rst & ~annul_i & ((state==IDLE & start_i) | state==MUL | state==DIV).
- IDLE with start_i=1 and annul_i=0, capture cycle (c0):
  - Latch |a| and |b|. Use absolute values only for MULT/DIV; MULTU/DIVU are taken as-is.
  - Latch sign_q = a[msb]^b[msb] and sign_r = a[msb] (both signed ops only).
  - Go to MUL for op_i[1]=0, otherwise go to DIV with counter=0.
- MUL:
  - One cycle: register the 2*WIDTH-bit unsigned product, negate it when sign_q (MULT), then go to DONE.
  - busy_o is high for 2 cycles; valid_o rises on c2.
- DIV, restoring radix-2:
  - Each cycle shift the {rem,quot} pair left one bit.
  - Trial-subtract the divisor; set the quotient LSB to 1 when the trial result is non-negative.
  - Leave DIV after WIDTH iterations (counter==WIDTH-1). On exit, negate quot when sign_q and rem when sign_r (DIV only), then go to DONE.
  - busy_o is high for WIDTH+1 cycles (33); valid_o rises on c33.
- Edge results:
  - 0x80000000 / -1 (DIV): lo=0x80000000, hi=0, no trap.
  - Divide by zero, any sign: lo=all ones, hi=a_i as captured (raw, not absolute value).
- DONE:
  - valid_o=1 and busy_o=0, so the pipeline advances this cycle.
  - Go to IDLE when stall_i=0; stay in DONE, holding hi_o, lo_o and valid_o, while stall_i=1.
  - start_i is ignored in DONE, so the departing instruction is never re-executed.
- Leaving DONE: valid_o clears on entry to IDLE. hi_o/lo_o keep their last values until the next completion.
- annul_i=1:
  - Forces busy_o=0 in the same cycle.
  - At the next edge the state goes to IDLE, valid_o=0, and the partial result is discarded.
  - annul_i has priority over start_i and over stall_i.
- start_i falling in MUL/DIV without annul_i is a protocol violation; the unit completes anyway and the result is unused.
- Back-to-back mul/div: the next start_i is seen in IDLE one cycle after DONE.

Optional Feature:
- MDU_DIV0_FAST_EN defined:
  - DIV/DIVU with b_i==0 at capture goes directly to DONE. busy_o is high for c0 only; same divide-by-zero result.
- Not defined:
  - Divide by zero runs the full 32 iterations (busy 33 cycles), giving the identical result.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> busy_o 2 cycles; valid_o then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9(-7), b=2 -> busy_o exactly 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. Busy 33 cycles without MDU_DIV0_FAST_EN, 1 cycle with it.
- DIV started, annul_i pulsed at iteration 10 -> busy_o=0 same cycle, IDLE next cycle, valid_o never asserts. A following MULTU 3*4 gives lo=12, hi=0.
- DIVU completes with stall_i=1 for 3 cycles -> DONE held 4 cycles with a stable result, no restart. rst=0 mid-DIV -> all outputs 0 next edge.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and result bundle between the E stage and the iterative
// multiply/divide unit.
//   start_i  : E-stage instruction is a mul/div (held while E is stalled)
//   op_i     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i : rs / rt operands after forwarding
//   annul_i  : E-stage exception, aborts the operation
//   stall_i  : external E stall, holds a finished result
//   busy_o   : unit is computing (drives isMulOrDivComputingE)
//   valid_o  : hi_o/lo_o hold the result of the E-stage instruction
//   hi_o     : product high word or remainder
//   lo_o     : product low word or quotient
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             annul_i;
  logic             stall_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, annul_i, stall_i,
    input  busy_o, valid_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, annul_i, stall_i,
    output busy_o, valid_o, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit for the E stage (MULT, MULTU, DIV, DIVU).
// Multiply takes one compute cycle after capture; divide is restoring
// radix-2, one quotient bit per cycle. The result is held in DONE until the
// pipeline is free to take it.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   bus : mdu_if.slave (start/op/operands/annul/stall in; busy/valid/hi/lo out)
//
// Optional build macro:
//   MDU_DIV0_FAST_EN : a divide by zero skips the iterations and goes
//                      straight from capture to DONE with the same result.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Datapath registers: |a| doubles as the dividend/quotient shift register,
  // |b| as the divisor; rem is the partial remainder.
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               sgnq_q, sgnq_d;
  logic               sgnr_q, sgnr_d;
  logic               div0_q, div0_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return $unsigned(-s);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    logic signed [2*WIDTH-1:0] s;
    s = $signed(v);
    return $unsigned(-s);
  endfunction

  // Capture-cycle operand conditioning
  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    signed_op, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]        a_abs, b_abs;

  assign a_s       = $signed(bus.a_i);
  assign b_s       = $signed(bus.b_i);
  assign signed_op = ~bus.op_i[0];
  assign a_neg     = signed_op & (a_s < 0);
  assign b_neg     = signed_op & (b_s < 0);
  assign b_zero    = (bus.b_i == '0);
  assign a_abs     = a_neg ? neg_w(bus.a_i) : bus.a_i;
  assign b_abs     = b_neg ? neg_w(bus.b_i) : bus.b_i;

  // Multiply stage: unsigned product of the magnitudes, sign restored after
  logic [2*WIDTH-1:0] prod_p1, prod_fix_p1;

  assign prod_p1     = {{WIDTH{1'b0}}, quot_q} * {{WIDTH{1'b0}}, dvsr_q};
  assign prod_fix_p1 = sgnq_q ? neg_2w(prod_p1) : prod_p1;

  // Divide iteration: shift {rem,quot} left, trial-subtract the divisor.
  // The shifted remainder can need WIDTH+1 bits, but whenever the trial
  // succeeds the difference is below the divisor, so WIDTH bits suffice.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff, step_rem, step_quot;
  logic             nonneg;

  assign rem_sh    = {rem_q, quot_q[WIDTH-1]};
  assign nonneg    = (rem_sh >= {1'b0, dvsr_q});
  assign diff      = rem_sh[WIDTH-1:0] - dvsr_q;
  assign step_rem  = nonneg ? diff : rem_sh[WIDTH-1:0];
  assign step_quot = {quot_q[WIDTH-2:0], nonneg};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    rem_d   = rem_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    div0_d  = div0_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          quot_d  = a_abs;
          dvsr_d  = b_abs;
          rem_d   = '0;
          cnt_d   = '0;
          sgnq_d  = a_neg ^ b_neg;
          sgnr_d  = a_neg;
          div0_d  = b_zero;
          state_d = bus.op_i[1] ? S_DIV : S_MUL;
`ifdef MDU_DIV0_FAST_EN
          if (bus.op_i[1] && b_zero) begin
            state_d = S_DONE;
            hi_d    = bus.a_i;
            lo_d    = '1;
          end
`endif
        end
      end
      S_MUL: begin
        hi_d    = prod_fix_p1[2*WIDTH-1:WIDTH];
        lo_d    = prod_fix_p1[WIDTH-1:0];
        state_d = S_DONE;
      end
      S_DIV: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Divide by zero leaves quot all ones and rem = |a|; undoing the
          // sign on rem gives back the raw dividend, but quot must stay all ones.
          lo_d    = (sgnq_q && !div0_q) ? neg_w(step_quot) : step_quot;
          hi_d    = sgnr_q ? neg_w(step_rem) : step_rem;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!bus.stall_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An E-stage exception wins over everything and discards partial work.
    if (bus.annul_i) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  assign valid_d = (state_d == S_DONE);

  // Control and architectural result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Working datapath registers, always reloaded at capture
  always_ff @(posedge clk) begin
    quot_q <= quot_d;
    dvsr_q <= dvsr_d;
    rem_q  <= rem_d;
    sgnq_q <= sgnq_d;
    sgnr_q <= sgnr_d;
    div0_q <= div0_d;
  end

  assign bus.busy_o  = rst & ~bus.annul_i &
                       (((state_q == S_IDLE) & bus.start_i) |
                        (state_q == S_MUL) | (state_q == S_DIV));
  assign bus.valid_o = valid_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;
  localparam int W = 32;
`ifdef MDU_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_iterative #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero
  // with the remainder taking the dividend's sign, as the ISA requires.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'd2: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
  endtask

  function automatic int exp_busy(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return 2;
    if (FAST && b == 0) return 1;
    return 33;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int nstall);
    logic [31:0] eh, el;
    int bc, cyc, eb;
    model(op, a, b, eh, el);
    eb = exp_busy(op, b);
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.stall_i = 1'b0;
    #1;
    bc = 0; cyc = 0;
    while (bus.valid_o !== 1'b1 && cyc < 100) begin
      if (bus.busy_o === 1'b1) bc++;
      @(posedge clk); #2;
      cyc++;
    end
    check({tag, "_valid"}, 64'(bus.valid_o), 64'(1));
    check({tag, "_busycnt"}, 64'(bc), 64'(eb));
    check({tag, "_latency"}, 64'(cyc), 64'(eb));
    check({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, {eh, el});
    check({tag, "_done_busy"}, 64'(bus.busy_o), 64'(0));
    bus.stall_i = (nstall > 0);
    for (int k = 1; k <= nstall; k++) begin
      @(posedge clk); #1;
      bus.stall_i = (k < nstall);
      #1;
      check({tag, "_hold_valid"}, {62'd0, bus.valid_o, bus.busy_o}, 64'd2);
      check({tag, "_hold_hilo"}, {bus.hi_o, bus.lo_o}, {eh, el});
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.stall_i = 1'b0;
    #1;
    check({tag, "_idle"}, {62'd0, bus.valid_o, bus.busy_o}, 64'd0);
    check({tag, "_keep_hilo"}, {bus.hi_o, bus.lo_o}, {eh, el});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int sel, nv;

    // Reset with a pending start: busy must stay low, outputs cleared
    rst = 1'b0;
    bus.start_i = 1'b1; bus.op_i = 2'd2; bus.a_i = 32'd9; bus.b_i = 32'd2;
    bus.annul_i = 1'b0; bus.stall_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("rst_busy", 64'(bus.busy_o), 64'(0));
    check("rst_outs", {31'd0, bus.valid_o, bus.hi_o}, 64'd0);
    check("rst_lo", 64'(bus.lo_o), 64'(0));
    bus.start_i = 1'b0;
    rst = 1'b1;

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 0);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div_neg7", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_zero", 2'd3, 32'h1234_5678, 32'd0, 0);
    run_op("div_zero_neg", 2'd2, 32'h8765_4321, 32'd0, 1);
    run_op("divu_stall", 2'd3, 32'd1000, 32'd7, 3);

    // Annul a divide at iteration 10
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 2'd2; bus.a_i = 32'd12345; bus.b_i = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
    end
    bus.annul_i = 1'b1;
    #1;
    check("annul_busy_now", 64'(bus.busy_o), 64'(0));
    @(posedge clk); #1;
    bus.annul_i = 1'b0; bus.start_i = 1'b0;
    #1;
    check("annul_idle", {62'd0, bus.valid_o, bus.busy_o}, 64'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) nv++;
    end
    check("annul_no_valid", 64'(nv), 64'(0));
    run_op("after_annul", 2'd1, 32'd3, 32'd4, 0);

    // Reset in the middle of a divide
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 2'd3; bus.a_i = 32'd100; bus.b_i = 32'd7;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy_o), 64'(0));
    @(posedge clk); #2;
    check("midrst_outs", {31'd0, bus.valid_o, bus.hi_o}, 64'd0);
    check("midrst_lo", 64'(bus.lo_o), 64'(0));
    rst = 1'b1; bus.start_i = 1'b0;
    run_op("after_rst", 2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0);

    // Randomized operations including corner operands
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
      else rb = $urandom;
      run_op("rand", rop, ra, rb, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
